// File: rtl/fetch_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_pkg
//   Shared constants for the instruction-fetch sequencer and its return stack:
//   bus-cycle state encoding, opcode values the sequencer must recognise, the
//   program-counter width, return-stack depth and small decode helpers.
// -----------------------------------------------------------------------------
package fetch_sequencer_pkg;

    localparam int unsigned PC_W        = 12;
    localparam int unsigned STACK_DEPTH = 3;

    // Eight-phase bus cycle: three address nibbles out, two ROM nibbles in,
    // three execute phases.
    typedef enum logic [2:0] {
        ST_A1 = 3'd0,
        ST_A2 = 3'd1,
        ST_A3 = 3'd2,
        ST_M1 = 3'd3,
        ST_M2 = 3'd4,
        ST_X1 = 3'd5,
        ST_X2 = 3'd6,
        ST_X3 = 3'd7
    } bus_state_e;

    // Opcode (upper nibble of the first word) values that affect sequencing.
    localparam logic [3:0] OPR_JCN = 4'h1;
    localparam logic [3:0] OPR_FIM = 4'h2;
    localparam logic [3:0] OPR_JUN = 4'h4;
    localparam logic [3:0] OPR_JMS = 4'h5;
    localparam logic [3:0] OPR_ISZ = 4'h7;
    localparam logic [3:0] OPR_BBL = 4'hC;

    // Next bus phase; the 3-bit encoding wraps X3 -> A1 on its own.
    function automatic bus_state_e next_state(input bus_state_e s);
        return bus_state_e'(3'(s) + 3'd1);
    endfunction

    // True when the first word (opr, operand) is followed by a second word.
    // Opcode 0x2 is FIM only with an even operand; odd operand is SRC.
    function automatic logic is_two_word(input logic [3:0] opr,
                                         input logic [3:0] operand);
        logic two;
        two = 1'b0;
        case (opr)
            OPR_JCN, OPR_JUN, OPR_JMS, OPR_ISZ: two = 1'b1;
            OPR_FIM:                            two = ~operand[0];
            default:                            two = 1'b0;
        endcase
        return two;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// -----------------------------------------------------------------------------
// fetch_sequencer_if
//   Nibble-wide ROM bus between the fetch sequencer (master) and the ROM or
//   testbench (slave).
//     data_in  : 4  nibble returned by the ROM during M1/M2
//     data_out : 4  address nibble driven during A1/A2/A3
//     data_oe  : 1  high while data_out is valid (A1..A3)
//     sync     : 1  high in X3, marks the start of the next bus cycle
// -----------------------------------------------------------------------------
interface fetch_sequencer_if;

    logic [3:0] data_in;
    logic [3:0] data_out;
    logic       data_oe;
    logic       sync;

    modport master (
        input  data_in,
        output data_out,
        output data_oe,
        output sync
    );

    modport slave (
        output data_in,
        input  data_out,
        input  data_oe,
        input  sync
    );

endinterface

// File: rtl/fetch_sequencer_pc_stack.sv
// -----------------------------------------------------------------------------
// pc_stack
//   Three-entry subroutine return stack used as a circular buffer.
//     clock, reset : synchronous active-high reset clears entries and pointer
//     push_i       : write data_i at the pointer, advance pointer (mod 3)
//     pop_i        : retreat pointer (mod 3); data_o is the entry popped
//     data_i       : 12  return address to push
//     data_o       : 12  current top-of-stack (entry below the pointer)
//   A fourth push overwrites the oldest entry and popping an empty stack just
//   returns whatever entry the pointer wraps onto; neither is flagged.
// -----------------------------------------------------------------------------
module pc_stack
    import fetch_sequencer_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] data_i,
    output logic [PC_W-1:0] data_o
);

    logic [PC_W-1:0] entry_q [STACK_DEPTH];
    logic [1:0]      ptr_q;
    logic [1:0]      ptr_prev;
    logic [1:0]      ptr_next;

    always_comb begin
        ptr_prev = (ptr_q == 2'd0) ? 2'd2 : ptr_q - 2'd1;
        ptr_next = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
    end

    assign data_o = entry_q[ptr_prev];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            ptr_q <= '0;
        end else if (push_i) begin
            entry_q[ptr_q] <= data_i;
            ptr_q          <= ptr_next;
        end else if (pop_i) begin
            ptr_q <= ptr_prev;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// -----------------------------------------------------------------------------
// fetch_sequencer
//   Eight-phase instruction fetch sequencer for a nibble-serial ROM bus.
//   Each bus cycle sends the 12-bit pc as three nibbles, reads an opcode and
//   operand nibble back, then spends three execute phases. Two-word
//   instructions (JCN, FIM, JUN, JMS, ISZ) spend a second bus cycle fetching
//   an 8-bit word2; jumps, calls and returns are resolved at X3.
//   Ports:
//     clock, reset  : system clock, synchronous active-high reset
//     bus           : ROM bus (data_in/data_out/data_oe/sync), master side
//     take_branch   : JCN condition, sampled at X3 of the second word only
//     reg_is_zero   : ISZ condition, sampled at X3 of the second word only
//     inst_opr      : 4  opcode of the current first word
//     inst_operand  : 4  operand of the current first word
//     inst_valid    : 1  one-clock pulse in X1 of every first-word cycle
//     second_word   : 1  high for the whole second cycle of a two-word instr
//     pc            : 12 program counter
// -----------------------------------------------------------------------------
module fetch_sequencer
    import fetch_sequencer_pkg::*;
(
    input  logic                     clock,
    input  logic                     reset,
    fetch_sequencer_if.master        bus,
    input  logic                     take_branch,
    input  logic                     reg_is_zero,
    output logic [3:0]               inst_opr,
    output logic [3:0]               inst_operand,
    output logic                     inst_valid,
    output logic                     second_word,
    output logic [PC_W-1:0]          pc
);

    bus_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [3:0]      opr_q;
    logic [3:0]      operand_q;
    logic [7:0]      word2_q;
    logic            valid_q;
    logic            second_q;
    logic            sync_q;

    logic            stack_push;
    logic            stack_pop;
    logic [PC_W-1:0] stack_top;

    // Calls push the already-incremented pc (address after the second word);
    // BBL is single-word, so it pops at X3 of its own first-word cycle.
    always_comb begin
        stack_push = (state_q == ST_X3) &&  second_q && (opr_q == OPR_JMS);
        stack_pop  = (state_q == ST_X3) && !second_q && (opr_q == OPR_BBL);
    end

    pc_stack u_pc_stack (
        .clock  (clock),
        .reset  (reset),
        .push_i (stack_push),
        .pop_i  (stack_pop),
        .data_i (pc_q),
        .data_o (stack_top)
    );

    // In-page targets take pc[11:8] after the M2 increment, so a second word
    // sitting at xFF lands on the following page.
    always_comb begin
        pc_d = pc_q;
        case (state_q)
            ST_M2: pc_d = pc_q + 12'd1;
            ST_X3: begin
                if (second_q) begin
                    case (opr_q)
                        OPR_JUN, OPR_JMS: pc_d = {operand_q, word2_q};
                        OPR_JCN: if (take_branch)  pc_d = {pc_q[11:8], word2_q};
                        OPR_ISZ: if (!reg_is_zero) pc_d = {pc_q[11:8], word2_q};
                        default: pc_d = pc_q;
                    endcase
                end else if (opr_q == OPR_BBL) begin
                    pc_d = stack_top;
                end
            end
            default: pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_A1;
            pc_q      <= '0;
            opr_q     <= '0;
            operand_q <= '0;
            word2_q   <= '0;
            valid_q   <= 1'b0;
            second_q  <= 1'b0;
            sync_q    <= 1'b0;
        end else begin
            state_q <= next_state(state_q);
            pc_q    <= pc_d;
            // Registered flags are set one phase early so they are high
            // exactly during X3 (sync) and X1 (inst_valid).
            sync_q  <= (state_q == ST_X2);
            valid_q <= (state_q == ST_M2) && !second_q;
            case (state_q)
                ST_M1: begin
                    if (second_q) word2_q[7:4] <= bus.data_in;
                    else          opr_q        <= bus.data_in;
                end
                ST_M2: begin
                    if (second_q) word2_q[3:0] <= bus.data_in;
                    else          operand_q    <= bus.data_in;
                end
                // Changes only at the cycle boundary, so second_word covers
                // A1..X3 of the second cycle and drops at the next A1.
                ST_X3: second_q <= !second_q && is_two_word(opr_q, operand_q);
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.data_out = '0;
        bus.data_oe  = 1'b0;
        case (state_q)
            ST_A1: begin bus.data_out = pc_q[3:0];  bus.data_oe = 1'b1; end
            ST_A2: begin bus.data_out = pc_q[7:4];  bus.data_oe = 1'b1; end
            ST_A3: begin bus.data_out = pc_q[11:8]; bus.data_oe = 1'b1; end
            default: ;
        endcase
    end

    assign bus.sync     = sync_q;
    assign inst_opr     = opr_q;
    assign inst_operand = operand_q;
    assign inst_valid   = valid_q;
    assign second_word  = second_q;
    assign pc           = pc_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// tb_fetch_sequencer
//   Drives fetch_sequencer from a byte-wide ROM model. Expected fetch
//   addresses are queued per program and popped each time a full address
//   has been sent on the bus; per-phase outputs are checked against a
//   bench-side phase counter and second-word model.
// -----------------------------------------------------------------------------
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        take_branch;
    logic        reg_is_zero;
    logic [3:0]  inst_opr;
    logic [3:0]  inst_operand;
    logic        inst_valid;
    logic        second_word;
    logic [11:0] pc;

    fetch_sequencer_if bus ();

    fetch_sequencer dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus),
        .take_branch  (take_branch),
        .reg_is_zero  (reg_is_zero),
        .inst_opr     (inst_opr),
        .inst_operand (inst_operand),
        .inst_valid   (inst_valid),
        .second_word  (second_word),
        .pc           (pc)
    );

    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic two_word(input logic [7:0] b);
        case (b[7:4])
            4'h1, 4'h4, 4'h5, 4'h7: return 1'b1;
            4'h2:                   return ~b[0];
            default:                return 1'b0;
        endcase
    endfunction

    // ROM model and bench phase counter (0=A1 .. 7=X3).
    logic [7:0]  rom [4096];
    logic [2:0]  ph;
    logic [11:0] cur_addr;
    logic        br_x3;
    logic        z_x3;

    always @(posedge clock) ph <= reset ? 3'd0 : ph + 3'd1;

    assign bus.data_in = (ph == 3'd3) ? rom[cur_addr][7:4] :
                         (ph == 3'd4) ? rom[cur_addr][3:0] : 4'h0;

    // Condition inputs carry the opposite value outside X3 so any sampling
    // at the wrong phase changes control flow.
    assign take_branch = (ph == 3'd7) ? br_x3 : ~br_x3;
    assign reg_is_zero = (ph == 3'd7) ? z_x3  : ~z_x3;

    logic [11:0] exp_addr_q [$];
    logic        model_sw;
    logic [7:0]  first_byte;
    logic [11:0] exp_a;

    always @(negedge clock) begin
        if (reset) begin
            model_sw = 1'b0;
        end else begin
            check("data_oe", 32'(bus.data_oe), 32'(ph < 3'd3));
            check("sync", 32'(bus.sync), 32'(ph == 3'd7));
            check("inst_valid", 32'(inst_valid), 32'(ph == 3'd5 && !model_sw));
            check("second_word", 32'(second_word), 32'(model_sw));
            case (ph)
                3'd0: cur_addr[3:0] = bus.data_out;
                3'd1: cur_addr[7:4] = bus.data_out;
                3'd2: begin
                    cur_addr[11:8] = bus.data_out;
                    if (exp_addr_q.size() != 0) begin
                        exp_a = exp_addr_q.pop_front();
                        check("fetch_addr", 32'(cur_addr), 32'(exp_a));
                        check("pc", 32'(pc), 32'(exp_a));
                    end
                end
                3'd4: if (!model_sw) first_byte = rom[cur_addr];
                3'd5: if (!model_sw) begin
                    check("inst_opr", 32'(inst_opr), 32'(first_byte[7:4]));
                    check("inst_operand", 32'(inst_operand), 32'(first_byte[3:0]));
                end
                3'd7: model_sw = !model_sw && two_word(first_byte);
                default: ;
            endcase
        end
    end

    // Caller is just after a posedge; holds reset one cycle and checks state.
    task automatic assert_reset();
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("rst_pc", 32'(pc), 0);
        check("rst_sync", 32'(bus.sync), 0);
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_second", 32'(second_word), 0);
        check("rst_opr", 32'(inst_opr), 0);
        check("rst_operand", 32'(inst_operand), 0);
        check("rst_oe", 32'(bus.data_oe), 1);
        check("rst_dout", 32'(bus.data_out), 0);
    endtask

    task automatic release_reset();
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    endtask

    task automatic start_test();
        @(posedge clock);
        #1;
        assert_reset();
        clear_rom();
        br_x3 = 1'b0;
        z_x3  = 1'b0;
    endtask

    task automatic drain(input int unsigned max_cycles);
        int unsigned n;
        n = 0;
        while (exp_addr_q.size() != 0 && n < max_cycles) begin
            @(posedge clock);
            n++;
        end
        check("drain_left", 32'(exp_addr_q.size()), 0);
        exp_addr_q.delete();
    endtask

    task automatic push3(input logic [11:0] a, input logic [11:0] b,
                         input logic [11:0] c);
        exp_addr_q.push_back(a);
        exp_addr_q.push_back(b);
        exp_addr_q.push_back(c);
    endtask

    initial begin
        logic found;
        br_x3 = 1'b0;
        z_x3  = 1'b0;
        cur_addr = '0;
        first_byte = '0;
        model_sw = 1'b0;
        clear_rom();

        // All-zero ROM: sequential fetch, pulses every 8 clocks.
        start_test();
        release_reset();
        push3(12'h000, 12'h001, 12'h002);
        exp_addr_q.push_back(12'h003);
        drain(64);

        // JUN 0xABC.
        start_test();
        rom[12'h000] = 8'h4A; rom[12'h001] = 8'hBC;
        release_reset();
        push3(12'h000, 12'h001, 12'hABC);
        exp_addr_q.push_back(12'hABD);
        drain(64);

        // JMS 0x123 from 0x010, BBL back to 0x012.
        start_test();
        rom[12'h000] = 8'h40; rom[12'h001] = 8'h10;
        rom[12'h010] = 8'h51; rom[12'h011] = 8'h23;
        rom[12'h123] = 8'hC0;
        release_reset();
        push3(12'h000, 12'h001, 12'h010);
        push3(12'h011, 12'h123, 12'h012);
        exp_addr_q.push_back(12'h013);
        drain(96);

        // JCN across page boundary, taken and not taken.
        for (int t = 0; t < 2; t++) begin
            start_test();
            rom[12'h000] = 8'h40; rom[12'h001] = 8'hFE;
            rom[12'h0FE] = 8'h11; rom[12'h0FF] = 8'h40;
            br_x3 = (t == 0);
            release_reset();
            push3(12'h000, 12'h001, 12'h0FE);
            exp_addr_q.push_back(12'h0FF);
            exp_addr_q.push_back((t == 0) ? 12'h140 : 12'h100);
            drain(64);
        end

        // ISZ loops while not zero, then falls through into FIM and SRC.
        start_test();
        rom[12'h000] = 8'h71; rom[12'h001] = 8'h00;
        rom[12'h002] = 8'h20; rom[12'h003] = 8'hFF;
        rom[12'h004] = 8'h21; rom[12'h005] = 8'h45;
        release_reset();
        push3(12'h000, 12'h001, 12'h000);
        drain(64);
        z_x3 = 1'b1;
        push3(12'h001, 12'h002, 12'h003);
        exp_addr_q.push_back(12'h004);
        exp_addr_q.push_back(12'h005);
        drain(96);

        // Four nested calls, four returns; the fourth pop wraps to 0x302.
        start_test();
        rom[12'h000] = 8'h51; rom[12'h001] = 8'h00;
        rom[12'h100] = 8'h52; rom[12'h101] = 8'h00;
        rom[12'h200] = 8'h53; rom[12'h201] = 8'h00;
        rom[12'h300] = 8'h54; rom[12'h301] = 8'h00;
        rom[12'h400] = 8'hC0; rom[12'h302] = 8'hC0;
        rom[12'h202] = 8'hC0; rom[12'h102] = 8'hC0;
        release_reset();
        push3(12'h000, 12'h001, 12'h100);
        push3(12'h101, 12'h200, 12'h201);
        push3(12'h300, 12'h301, 12'h400);
        push3(12'h302, 12'h202, 12'h102);
        exp_addr_q.push_back(12'h302);
        drain(160);

        // pc wraps 0xFFF -> 0x000.
        start_test();
        rom[12'h000] = 8'h4F; rom[12'h001] = 8'hFE;
        release_reset();
        push3(12'h000, 12'h001, 12'hFFE);
        push3(12'hFFF, 12'h000, 12'h001);
        drain(80);

        // Reset during M1 of a JUN second word abandons the jump.
        start_test();
        rom[12'h000] = 8'h4A; rom[12'h001] = 8'hBC;
        release_reset();
        exp_addr_q.push_back(12'h000);
        drain(16);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            if (ph == 3'd3 && model_sw) begin
                found = 1'b1;
                break;
            end
        end
        check("wait_word2_m1", 32'(found), 1);
        assert_reset();
        release_reset();
        push3(12'h000, 12'h001, 12'hABC);
        drain(64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0x1 expected 0x0");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 SHALL have ports: clock  in  1  system clock; reset  in  1  synchronous, active-high reset.
REQ-002 SHALL have data_in  in  4  bus nibble returned by ROM during M1/M2.
REQ-003 SHALL have data_out  out  4  address nibble driven during A1/A2/A3, and data_oe  out  1  high only in A1..A3.
REQ-004 SHALL have sync  out  1  high during X3, marking the start of the next bus cycle.
REQ-005 SHALL have inst_opr  out  4  and inst_operand  out  4  holding the first-word opcode and operand for the datapath and decoder.
REQ-006 SHALL have inst_valid  out  1  one-clock pulse in X1 of every first-word cycle, and second_word  out  1  high for the whole second cycle of a two-word instruction.
REQ-007 SHALL have take_branch  in  1  and reg_is_zero  in  1  condition results from the datapath.
REQ-008 SHALL have pc  out  12  current program counter (debug and verification).

Function
REQ-009 SHALL sequence an 8-state bus cycle A1,A2,A3,M1,M2,X1,X2,X3, one state per clock, wrapping X3->A1.
REQ-010 SHALL drive data_out = pc[3:0] in A1, pc[7:4] in A2 and pc[11:8] in A3.
REQ-011 SHALL increment pc modulo 4096 at the end of M2 (0xFFF -> 0x000).
REQ-012 SHALL in a first-word cycle latch data_in into inst_opr at M1 and into inst_operand at M2; both SHALL hold until the next first-word M1.
REQ-013 SHALL in a second-word cycle latch the M1/M2 nibbles into an internal 8-bit word2 register and leave inst_opr/inst_operand unchanged.
REQ-014 SHALL treat as two-word: opr 0x1 (JCN), 0x2 with operand[0]=0 (FIM), 0x4 (JUN), 0x5 (JMS), 0x7 (ISZ). All other opcodes are single-word.
REQ-015 SHALL resolve control flow at X3 of the second word:
- JUN: pc <= {inst_operand, word2}.
- JMS: push pc, then pc <= {inst_operand, word2}.
- JCN: if take_branch, pc <= {pc[11:8], word2}.
- ISZ: if !reg_is_zero, pc <= {pc[11:8], word2}.
- FIM: pc unchanged.
REQ-016 SHALL use pc[11:8] after the REQ-011 increment for in-page targets, so that a JCN/ISZ whose second word is at xFF targets the next page.
REQ-017 SHALL on BBL (opr 0xC, single-word) pop the stack into pc at X3 of that cycle.
REQ-018 SHALL keep a 3-entry return stack with a 2-bit pointer. A push at depth 3 SHALL overwrite the oldest entry; a pop of an empty stack SHALL return the wrapped entry, and neither case SHALL raise an error.
REQ-019 SHALL sample take_branch and reg_is_zero only at X3 of a second-word cycle; values at other times SHALL have no effect.
REQ-020 SHALL deassert second_word at A1 of the cycle that follows the second word.

Reset
REQ-021 SHALL on reset enter state A1 with pc=0, all stack entries and the pointer 0, inst_opr=inst_operand=word2=0, second_word=0, inst_valid=0 and sync=0.
REQ-022 SHALL abandon any in-flight instruction when reset is asserted mid-cycle; the first cycle after reset SHALL fetch address 0x000 as a first word.

Structure
REQ-023 SHALL take the bus-state encodings and opcode constants (JCN, FIM, JUN, JMS, ISZ, BBL) from the shared datapath include file alongside the existing select constants.
REQ-024 SHALL implement the return stack as a sub-module, pc_stack (push, pop, data in/out, 3 entries), instantiated once.

Verification
REQ-025 Reset, then ROM returns 0x00 at every address -> data_out sequence 0,0,0 then 1,0,0; inst_valid pulses every 8 clocks; sync high on clock 8.
REQ-026 JUN 0x4A then 0xBC at 0x000 -> second_word high on the second cycle; next fetch address 0xABC.
REQ-027 JMS 0x51 then 0x23 at 0x010, then BBL at 0x123 -> fetches 0x123, then 0x012.
REQ-028 JCN at 0x0FE/0x0FF with word2=0x40 and take_branch=1 at X3 -> next address 0x140. With take_branch=0 -> next address 0x100.
REQ-029 ISZ with reg_is_zero=0 loops to the target address; with reg_is_zero=1 it falls through to pc+2.
REQ-030 Four nested JMS followed by four BBL -> the first three pops return the correct addresses in LIFO order. Separately, reset asserted during M1 of a JUN second word -> the next fetch is 0x000.
